// File: rtl/cnn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cnn_pkg                                                              |
// | Frame geometry, kernel size and window packing shared by the CNN.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cnn_pkg;

    localparam int IMG_W = 28;
    localparam int IMG_H = 28;
    localparam int K     = 5;
    localparam int PIX_W = 8;

    localparam int WIN_N = K * K;
    localparam int WIN_W = WIN_N * PIX_W;

    typedef logic [PIX_W-1:0] pix_t;

    // Element index inside a flat window / weight bus; r=0 is the oldest row.
    function automatic int win_idx(input int r, input int c);
        return r * K + c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv1_window_rx_row_delay.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | row_delay                                                            |
// | Enable-gated delay of exactly one image row (DEPTH accepted pixels). |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module row_delay
    import cnn_pkg::*;
#(
    parameter int WIDTH = PIX_W,
    parameter int DEPTH = IMG_W
) (
    input  logic             clk,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    // Contents are never cleared; the window gating keeps stale data out.
    logic [WIDTH-1:0] r_mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end
    end

    assign o_data = r_mem[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/conv1_window_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conv1_window_rx                                                      |
// | Raster pixel stream in, every KxK neighbourhood out as a flat window.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module conv1_window_rx
    import cnn_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [PIX_W-1:0] data_in,
    output logic [0:WIN_W-1] window,
    output logic             valid_out,
    output logic             frame_done
);

    localparam int c_col_w = $clog2(IMG_W);
    localparam int c_row_w = $clog2(IMG_H);

    localparam logic [c_col_w-1:0] c_col_last  = c_col_w'(IMG_W - 1);
    localparam logic [c_row_w-1:0] c_row_last  = c_row_w'(IMG_H - 1);
    localparam logic [c_col_w-1:0] c_col_first = c_col_w'(K - 1);
    localparam logic [c_row_w-1:0] c_row_first = c_row_w'(K - 1);

    logic [c_col_w-1:0] r_col;
    logic [c_row_w-1:0] r_row;

    pix_t r_win      [0:K-1][0:K-1];
    pix_t w_win_next [0:K-1][0:K-1];
    pix_t w_line_q   [0:K-2];
    pix_t w_tap      [0:K-1];

    logic [0:WIN_W-1] w_win_flat;
    logic             w_accept;
    logic             w_qual;
    logic             w_last;

    // Reset beats a coincident pixel, so the pixel must not touch any state.
    assign w_accept = valid_in && !rst;
    assign w_qual   = w_accept && (r_row >= c_row_first) && (r_col >= c_col_first);
    assign w_last   = (r_row == c_row_last) && (r_col == c_col_last);

    generate
        for (genvar j = 0; j < K - 1; j++) begin : g_line
            if (j == 0) begin : g_head
                row_delay #(
                    .WIDTH (PIX_W),
                    .DEPTH (IMG_W)
                ) u_row_delay (
                    .clk    (clk),
                    .i_en   (w_accept),
                    .i_data (data_in),
                    .o_data (w_line_q[j])
                );
            end else begin : g_chain
                row_delay #(
                    .WIDTH (PIX_W),
                    .DEPTH (IMG_W)
                ) u_row_delay (
                    .clk    (clk),
                    .i_en   (w_accept),
                    .i_data (w_line_q[j-1]),
                    .o_data (w_line_q[j])
                );
            end
        end
    endgenerate

    // The deepest delay line holds the oldest row, which becomes window row 0.
    always_comb begin
        w_tap[K-1] = data_in;
        for (int j = 0; j < K - 1; j++) begin
            w_tap[K-2-j] = w_line_q[j];
        end
    end

    always_comb begin
        w_win_next = r_win;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                w_win_next[r][c] = r_win[r][c+1];
            end
            w_win_next[r][K-1] = w_tap[r];
        end
    end

    always_comb begin
        w_win_flat = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                w_win_flat[PIX_W*win_idx(r, c) +: PIX_W] = w_win_next[r][c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_win <= w_win_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col      <= '0;
            r_row      <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            window     <= '0;
        end else begin
            valid_out  <= w_qual;
            frame_done <= w_qual && w_last;
            if (w_qual) begin
                window <= w_win_flat;
            end
            if (w_accept) begin
                if (r_col == c_col_last) begin
                    r_col <= '0;
                    r_row <= (r_row == c_row_last) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/conv1_window_rx.md
# conv1_window_rx

Receive end of the serial pixel interface feeding the CNN datapath. Accepts one 8-bit pixel per cycle in raster order (row-major, 28x28 MNIST frame) and emits every 5x5 neighbourhood as a flat 200-bit window for conv1. The window is packed identically to the conv1 weight buses. Sits between the pixel source and the conv1 MAC array, replacing per-engine ad-hoc buffering.

## Interface
- IMG_W, 28, pixels per row
- IMG_H, 28, rows per frame
- K, 5, kernel edge
- PIX_W, 8, bits per pixel (unsigned)

- clk  in  1  rising-edge clock; single clock domain
- rst  in  1  synchronous, active-high reset
- valid_in  in  1  data_in carries a pixel this cycle
- data_in  in  PIX_W  pixel, raster order
- window  out  [0:K*K*PIX_W-1]  5x5 window; element i = r*K+c at [(PIX_W*i)+:PIX_W], r=0 oldest row, c=0 leftmost column
- valid_out  out  1  window valid, 1-cycle pulse per window
- frame_done  out  1  pulses with the last window of a frame

## Operation
- col (0..IMG_W-1) and row (0..IMG_H-1) counters advance only on valid_in. col wraps to 0 and increments row. row wraps to 0 after pixel (IMG_H-1, IMG_W-1).
- K-1 row-delay lines, each IMG_W deep, are chained. Their taps plus data_in form a K-tall column that shifts into a KxK register array. Column 0 is dropped on each shift.
- A window is emitted for accepted pixel (r,c) iff r >= K-1 and c >= K-1. It holds rows r-K+1..r and cols c-K+1..c.
- Per frame: exactly (IMG_W-K+1)*(IMG_H-K+1) = 576 windows. No window straddles a row edge or a frame boundary.
- valid_in low: all state holds. valid_out is deasserted. window holds its last value.
- No backpressure. The downstream must absorb one window per cycle.
- Pixel data is unsigned and is passed through without arithmetic.
- The count registers are sized to clog2 of IMG_W and IMG_H.

## Timing
- Latency: 1 cycle. valid_out and window are registered in the cycle after the qualifying pixel is accepted.
- frame_done is asserted in the same cycle as valid_out for pixel (IMG_H-1, IMG_W-1).
- Reset values: valid_out=0, frame_done=0, window=0, col=0, row=0.
- Delay-line contents are not cleared. Stale data can never reach a valid window because of the r/c gating.
- Reset mid-frame: the partial frame is discarded. The next accepted pixel is treated as (0,0). A reset on the same cycle as valid_in wins, and the pixel is dropped.
- Back-to-back frames need no idle cycles. Pixel (0,0) of frame n+1 may be accepted the cycle after the last pixel of frame n.
- Throughput: 1 pixel per clock, sustained.

## Structure
- Shared package cnn_pkg holds IMG_W, IMG_H, K, PIX_W and the window-index helper r*K+c. The conv1/conv2 engines use the same constants.
- One sub-module: row_delay, a PIX_W-wide, IMG_W-deep shift/RAM delay with an enable. It is instantiated K-1 times.
- The top level contains the counters, the KxK register array, and the output registers.

## Test plan
- **Ramp frame.** Stream pixel (r,c) = (r*28+c) mod 256 with valid_in held high.
  - The first valid_out follows the 117th pixel, with window[0]=0 and window[24]=116.
  - Exactly 576 valid_out pulses occur.
  - frame_done fires once, with window[24]=(783 mod 256)=15.
- **Random stalls.** Same frame, valid_in low about 40% of cycles.
  - The window sequence is identical to the ramp case.
  - valid_out is never high in a cycle after a stalled cycle.
- **Row edge.** For every row r >= 4, no valid_out follows pixels c=0..3.
  - The window after pixel (5,4) has window[0]=(1*28+0)=28.
- **Reset mid-frame.** Assert rst after 300 pixels, then stream a full ramp frame.
  - Exactly 576 windows are emitted, with the first window[0]=0.
- **Back-to-back frames.** Send two frames with no gap; frame 2 is the ramp plus 100.
  - No valid_out occurs during frame 2 pixels 0..115.
  - The first frame-2 window is window[0]=100.
- **Reset/valid collision.** Assert rst together with valid_in.
  - The pixel is dropped and valid_out=0 next cycle.
  - The following pixel is treated as (0,0).
